// File: rtl/max7219_frame_sched.sv
// MAX7219 serial frame scheduler: power-up wait, register init, then dirty-digit refresh
// arbitrated against raw host register writes over the 3-wire seg_clk/seg_cs/seg_din link.
module max7219_frame_sched #(
  parameter int         CLK_DIV      = 250,
  parameter int         POWERUP_WAIT = 50000,
  parameter logic [7:0] DECODE_MODE  = 8'hFF,
  parameter logic [7:0] INTENSITY    = 8'h03,
  parameter logic [7:0] SCAN_LIMIT   = 8'h07
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_digit,
  input  logic [7:0] wr_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       init_done,
  output logic       busy,
  output logic       seg_clk,
  output logic       seg_cs,
  output logic       seg_din,
  output logic [2:0] dbg_state_o
);

  // Host handshake: a command transfers in a cycle where cmd_valid and cmd_ready are both
  // high; cmd_ready only rises in IDLE after init, and the host holds cmd_valid until then.

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int PWR_W = (POWERUP_WAIT > 1) ? $clog2(POWERUP_WAIT) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [PWR_W-1:0] PWR_MAX = PWR_W'(POWERUP_WAIT - 1);

  localparam logic [2:0] S_PWR_WAIT = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_SHIFT    = 3'd3;
  localparam logic [2:0] S_LATCH    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [PWR_W-1:0] pwr_q, pwr_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       half_q, half_d;
  logic [2:0]       init_idx_q, init_idx_d;
  logic             init_done_q, init_done_d;
  logic [15:0]      frame_q, frame_d;
  logic [7:0]       digit_q [8];
  logic [7:0]       dirty_q;
  logic [7:0]       dirty_clr;
  logic [7:0]       wr_mask;
  logic [2:0]       pick;
  logic             seg_cs_q, seg_clk_q, seg_din_q;
  logic             seg_cs_d, seg_clk_d, seg_din_d;

  function automatic logic [15:0] init_frame(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'h0F00;
      3'd1:    return 16'h0C01;
      3'd2:    return {8'h0B, SCAN_LIMIT};
      3'd3:    return {8'h0A, INTENSITY};
      default: return {8'h09, DECODE_MODE};
    endcase
  endfunction

  // Lowest dirty index wins, so scan from the top down and let the last hit stand.
  always_comb begin
    pick = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (dirty_q[i]) pick = 3'(i);
    end
  end

  always_comb begin
    wr_mask = 8'h00;
    if (wr_en) wr_mask[wr_digit] = 1'b1;
  end

  assign cmd_ready   = (state_q == S_IDLE) && cmd_valid && init_done_q;
  assign busy        = (state_q != S_IDLE);
  assign init_done   = init_done_q;
  assign seg_cs      = seg_cs_q;
  assign seg_clk     = seg_clk_q;
  assign seg_din     = seg_din_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    pwr_d       = pwr_q;
    div_d       = div_q;
    half_d      = half_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    frame_d     = frame_q;
    dirty_clr   = 8'h00;
    case (state_q)
      S_PWR_WAIT: begin
        if (pwr_q == PWR_MAX) begin
          init_idx_d = 3'd0;
          frame_d    = init_frame(3'd0);
          state_d    = S_LOAD;
        end else begin
          pwr_d = pwr_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (cmd_valid && init_done_q) begin
          frame_d = {4'h0, cmd_addr, cmd_data};
          state_d = S_LOAD;
        end else if (|dirty_q) begin
          frame_d         = {4'h0, {1'b0, pick} + 4'd1, digit_q[pick]};
          dirty_clr[pick] = 1'b1;
          state_d         = S_LOAD;
        end
      end
      S_LOAD: begin
        div_d   = '0;
        half_d  = 5'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == DIV_MAX) begin
          div_d = '0;
          if (half_q == 5'd31) state_d = S_LATCH;
          else                 half_d  = half_q + 5'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (div_q == DIV_MAX) begin
          div_d = '0;
          if (init_done_q) begin
            state_d = S_IDLE;
          end else if (init_idx_q == 3'd4) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            init_idx_d = init_idx_q + 3'd1;
            frame_d    = init_frame(init_idx_q + 3'd1);
            state_d    = S_LOAD;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_PWR_WAIT;
    endcase
  end

  // Pins are registered from next-state so the link never sees decode glitches.
  always_comb begin
    seg_cs_d  = ~((state_d == S_LOAD) || (state_d == S_SHIFT));
    seg_clk_d = (state_d == S_SHIFT) && half_d[0];
    seg_din_d = 1'b0;
    if ((state_d == S_LOAD) || (state_d == S_SHIFT)) seg_din_d = frame_d[~half_d[4:1]];
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PWR_WAIT;
      pwr_q       <= '0;
      div_q       <= '0;
      half_q      <= 5'd0;
      init_idx_q  <= 3'd0;
      init_done_q <= 1'b0;
      frame_q     <= 16'h0000;
      seg_cs_q    <= 1'b1;
      seg_clk_q   <= 1'b0;
      seg_din_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_q       <= pwr_d;
      div_q       <= div_d;
      half_q      <= half_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      frame_q     <= frame_d;
      seg_cs_q    <= seg_cs_d;
      seg_clk_q   <= seg_clk_d;
      seg_din_q   <= seg_din_d;
    end
  end

  // A same-cycle write re-marks the digit dirty even as the scheduler clears it.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      dirty_q <= 8'hFF;
      for (int i = 0; i < 8; i++) digit_q[i] <= 8'h00;
    end else begin
      dirty_q <= (dirty_q & ~dirty_clr) | wr_mask;
      if (wr_en) digit_q[wr_digit] <= wr_data;
    end
  end

endmodule
